// File: rtl/fetch_pkg.sv
// fetch_pkg -- shared encodings and constants for the instruction-fetch controller.
// Rev 1.0
`default_nettype none

package fetch_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;

  localparam logic [1:0] ST_LOAD = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  typedef enum logic [1:0] {
    S_LOAD = ST_LOAD,
    S_RUN  = ST_RUN,
    S_HALT = ST_HALT
  } fetch_state_e;

endpackage

`default_nettype wire

// File: rtl/imem_load_counter.sv
// imem_load_counter -- loader word address with clear, increment and end-of-memory detect.
// Rev 1.0
`default_nettype none

module imem_load_counter #(
  parameter int MEM_DEPTH = 256,
  parameter int AW        = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          inc,
  input  logic          clr,
  output logic [AW-1:0] ld_addr,
  output logic          at_last
);

  // The top clears instead of incrementing on the final word, so no wrap occurs here.
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      ld_addr <= '0;
    end else if (inc) begin
      ld_addr <= ld_addr + 1'b1;
    end
  end

  assign at_last = (ld_addr == AW'(MEM_DEPTH - 1));

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// fetch_controller -- IF-stage sequencer: program loader port arbitration, PC control, IF/ID control.
// Rev 1.0
`default_nettype none

module fetch_controller
  import fetch_pkg::*;
#(
  parameter int B         = 32,
  parameter int MEM_DEPTH = 256,
  parameter int CNT_W     = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_valid,
  input  logic [INSTR_W-1:0] ld_data,
  input  logic               ld_last,
  output logic               ld_ready,
  input  logic               pc_src,
  input  logic [B-1:0]       pc_branch,
  input  logic               stall,
  input  logic               halt,
  output logic               im_en,
  output logic               im_we,
  output logic [B-1:0]       im_addr,
  output logic [INSTR_W-1:0] im_wdata,
  output logic [B-1:0]       pc,
  output logic [B-1:0]       pc_plus4,
  output logic               if_id_write,
  output logic               if_id_flush,
  output logic               running,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int AW = $clog2(MEM_DEPTH);

  fetch_state_e  state, state_next;
  logic [B-1:0]  pc_next;
  logic [AW-1:0] ld_addr;
  logic          ld_at_last;
  logic          ld_inc;
  logic          ld_clr;

  imem_load_counter #(
    .MEM_DEPTH (MEM_DEPTH),
    .AW        (AW)
  ) u_ld_cnt (
    .clk     (clk),
    .reset   (reset),
    .inc     (ld_inc),
    .clr     (ld_clr),
    .ld_addr (ld_addr),
    .at_last (ld_at_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next  = state;
    pc_next     = pc;
    ld_ready    = 1'b0;
    im_en       = 1'b0;
    im_we       = 1'b0;
    im_addr     = '0;
    im_wdata    = '0;
    if_id_write = 1'b0;
    if_id_flush = 1'b0;
    ld_inc      = 1'b0;
    ld_clr      = 1'b0;
    case (state)
      S_LOAD: begin
        ld_ready    = 1'b1;
        if_id_flush = 1'b1;
        pc_next     = '0;
        if (ld_valid) begin
          im_en    = 1'b1;
          im_we    = 1'b1;
          im_addr  = B'({ld_addr, 2'b00});
          im_wdata = ld_data;
          // Final word (explicit or end of memory) hands the port to fetch.
          if (ld_last || ld_at_last) begin
            ld_clr     = 1'b1;
            state_next = S_RUN;
          end else begin
            ld_inc = 1'b1;
          end
        end
      end
      S_RUN: begin
        im_addr = pc;
        im_en   = !stall || pc_src;
        if (pc_src) begin
          pc_next     = pc_branch;
          if_id_flush = 1'b1;
          if_id_write = 1'b1;
        end else if (halt) begin
          state_next = S_HALT;
        end else if (!stall) begin
          pc_next     = pc + B'(PC_STEP);
          if_id_write = 1'b1;
        end
      end
      S_HALT: begin
        im_addr = pc;
      end
      default: begin
        state_next = S_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= '0;
    end else begin
      pc <= pc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_count <= '0;
    end else if (state == S_RUN && cycle_count != '1) begin
      cycle_count <= cycle_count + 1'b1;
    end
  end

  assign pc_plus4 = pc + B'(PC_STEP);
  assign running  = (state == S_RUN);

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller -- directed self-checking bench for fetch_controller.
// Rev 1.0
`default_nettype none

module tb_fetch_controller;

  localparam int B         = 32;
  localparam int MEM_DEPTH = 16;
  localparam int CNT_W     = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             ld_valid;
  logic [31:0]      ld_data;
  logic             ld_last;
  logic             ld_ready;
  logic             pc_src;
  logic [B-1:0]     pc_branch;
  logic             stall;
  logic             halt;
  logic             im_en;
  logic             im_we;
  logic [B-1:0]     im_addr;
  logic [31:0]      im_wdata;
  logic [B-1:0]     pc;
  logic [B-1:0]     pc_plus4;
  logic             if_id_write;
  logic             if_id_flush;
  logic             running;
  logic [CNT_W-1:0] cycle_count;

  int n_checks = 0;
  int n_fails  = 0;
  int exp_cnt  = 0;
  bit exp_run  = 1'b0;

  always #5 clk = ~clk;

  fetch_controller #(
    .B         (B),
    .MEM_DEPTH (MEM_DEPTH),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_valid    (ld_valid),
    .ld_data     (ld_data),
    .ld_last     (ld_last),
    .ld_ready    (ld_ready),
    .pc_src      (pc_src),
    .pc_branch   (pc_branch),
    .stall       (stall),
    .halt        (halt),
    .im_en       (im_en),
    .im_we       (im_we),
    .im_addr     (im_addr),
    .im_wdata    (im_wdata),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .if_id_write (if_id_write),
    .if_id_flush (if_id_flush),
    .running     (running),
    .cycle_count (cycle_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; the expected run counter tracks the cycles the bench expects in RUN.
  task automatic tick();
    @(posedge clk);
    #1;
    if (exp_run && exp_cnt != (1 << CNT_W) - 1) exp_cnt++;
  endtask

  initial begin
    reset = 1'b1; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0;
    pc_src = 1'b0; pc_branch = '0; stall = 1'b0; halt = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rst_ld_ready", ld_ready, 1);
    chk("rst_im_en", im_en, 0);
    chk("rst_im_we", im_we, 0);
    chk("rst_im_addr", im_addr, 0);
    chk("rst_im_wdata", im_wdata, 0);
    chk("rst_if_id_write", if_id_write, 0);
    chk("rst_if_id_flush", if_id_flush, 1);
    chk("rst_running", running, 0);
    chk("rst_pc", pc, 0);
    chk("rst_cnt", cycle_count, 0);

    // Load four words, last flagged on the fourth.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1; ld_data = 32'h11 * (i + 1); ld_last = (i == 3);
      #1;
      chk("ld_we", im_we, 1);
      chk("ld_en", im_en, 1);
      chk("ld_addr", im_addr, i * 4);
      chk("ld_wdata", im_wdata, 32'h11 * (i + 1));
      tick();
    end
    ld_valid = 1'b0; ld_last = 1'b0;
    exp_run = 1'b1;
    #1;
    chk("first_running", running, 1);
    chk("first_im_addr", im_addr, 0);
    chk("first_im_en", im_en, 1);
    chk("first_ld_ready", ld_ready, 0);
    chk("first_write", if_id_write, 1);
    chk("first_flush", if_id_flush, 0);
    chk("first_cnt", cycle_count, 0);
    chk("first_pc_plus4", pc_plus4, 4);
    for (int i = 1; i < 4; i++) begin
      tick();
      chk("seq_pc", pc, i * 4);
      chk("seq_im_addr", im_addr, i * 4);
    end
    chk("seq_cnt", cycle_count, exp_cnt);

    // Three stall cycles hold the PC.
    for (int i = 0; i < 3; i++) begin
      stall = 1'b1;
      #1;
      chk("stall_write", if_id_write, 0);
      chk("stall_flush", if_id_flush, 0);
      chk("stall_im_en", im_en, 0);
      tick();
      chk("stall_pc", pc, 12);
    end
    stall = 1'b0;
    #1;
    chk("resume_write", if_id_write, 1);
    tick();
    chk("resume_pc", pc, 16);

    // Branch wins over simultaneous stall and halt.
    pc_src = 1'b1; pc_branch = 32'h40; stall = 1'b1; halt = 1'b1;
    #1;
    chk("br_flush", if_id_flush, 1);
    chk("br_write", if_id_write, 1);
    chk("br_im_en", im_en, 1);
    tick();
    pc_src = 1'b0; stall = 1'b0; halt = 1'b0;
    #1;
    chk("br_pc", pc, 32'h40);
    chk("br_running", running, 1);
    chk("br_flush_off", if_id_flush, 0);
    chk("br_cnt", cycle_count, 8);

    // Halt freezes PC and counter until reset.
    halt = 1'b1;
    #1;
    chk("halt_write", if_id_write, 0);
    tick();
    exp_run = 1'b0;
    halt = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
    end
    #1;
    chk("halt_running", running, 0);
    chk("halt_pc", pc, 32'h40);
    chk("halt_cnt", cycle_count, 9);
    chk("halt_ld_ready", ld_ready, 0);
    chk("halt_im_en", im_en, 0);
    chk("halt_write_off", if_id_write, 0);
    chk("halt_flush_off", if_id_flush, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_cnt = 0;
    #1;
    chk("halt_rst_running", running, 0);
    chk("halt_rst_pc", pc, 0);
    chk("halt_rst_cnt", cycle_count, 0);
    chk("halt_rst_ld_ready", ld_ready, 1);

    // Two words, then reset mid-load.
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_data = 32'hA0 + i;
      tick();
    end
    ld_valid = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Full-depth stream without ld_last forces RUN at the top address.
    for (int i = 0; i < MEM_DEPTH; i++) begin
      ld_valid = 1'b1; ld_data = 32'hB00 + i;
      #1;
      chk("strm_addr", im_addr, i * 4);
      chk("strm_we", im_we, 1);
      chk("strm_running", running, 0);
      tick();
    end
    exp_run = 1'b1;
    #1;
    chk("strm_run", running, 1);
    chk("strm_run_addr", im_addr, 0);
    chk("strm_run_we", im_we, 0);
    chk("strm_run_ready", ld_ready, 0);
    ld_valid = 1'b0;

    // Counter saturates at all-ones.
    for (int i = 0; i < 20; i++) begin
      tick();
    end
    chk("sat_cnt", cycle_count, exp_cnt);
    chk("sat_cnt_max", cycle_count, 15);
    chk("sat_pc", pc, 80);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

`default_nettype wire
